block_cmd_gen: RTL and testbench

Generates the move-command pulses `drop`, `left`, `right` and `ro` consumed by the block position register. It turns raw player buttons and an internal gravity timer into single-cycle, mutually exclusive command pulses. It adds input synchronisation, edge detection, horizontal auto-repeat, soft drop and fixed-priority arbitration. It sits between the board button inputs and the position register, and shares that register's `err` restart.

---
 rtl/block_cmd_gen.sv | 162 ++++++++++++++++
 tb/tb_block_cmd_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/block_cmd_gen.sv
// block_cmd_gen: turns raw player buttons and a gravity timer into
// single-cycle, mutually exclusive move commands (drop/left/right/ro)
// for the block position register. Everything restarts on err.
module block_cmd_gen #(
    parameter int unsigned GRAVITY_DIV  = 25_000_000,
    parameter int unsigned SOFT_DIV     = 2_500_000,
    parameter int unsigned REPEAT_DELAY = 10_000_000,
    parameter int unsigned REPEAT_RATE  = 3_000_000
) (
    input  logic clk,
    input  logic err,
    input  logic enable,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_rot,
    input  logic btn_down,
    output logic drop,
    output logic left,
    output logic right,
    output logic ro
);

    // Button bit positions inside the synchroniser vectors
    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_ROT   = 2;
    localparam int B_DOWN  = 3;

    // Terminal counts; counters run 0..N-1
    localparam logic [31:0] G_LAST     = GRAVITY_DIV - 1;
    localparam logic [31:0] S_LAST     = SOFT_DIV - 1;
    localparam logic [31:0] REP_LAST   = REPEAT_DELAY - 1;
    localparam logic [31:0] REP_RELOAD = REPEAT_DELAY - REPEAT_RATE;

    logic [3:0]  btn_raw;
    logic [3:0]  s1_q, s1_d;
    logic [3:0]  s2_q, s2_d;
    logic [3:0]  s3_q, s3_d;
    logic [3:0]  press;

    logic [31:0] gcnt_q, gcnt_d;
    logic [31:0] lcnt_q, lcnt_d;
    logic [31:0] rcnt_q, rcnt_d;
    logic [31:0] period_last;
    logic        gfire;
    logic        lreq;
    logic        rreq;

    // Pending flags and registered outputs, ordered {drop, left, right, rot}
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [3:0]  req;
    logic [3:0]  grant;

    assign btn_raw = {btn_down, btn_rot, btn_right, btn_left};

    assign drop  = cmd_q[3];
    assign left  = cmd_q[2];
    assign right = cmd_q[1];
    assign ro    = cmd_q[0];

    // One hold-counter step for a horizontal direction: returns {request, next count}.
    // A press restarts the count; reaching the delay reloads so later repeats
    // come every REPEAT_RATE cycles; releasing clears.
    function automatic logic [32:0] repeat_step(input logic pressed,
                                                input logic held,
                                                input logic [31:0] cnt);
        logic        r;
        logic [31:0] n;
        r = 1'b0;
        n = 32'd0;
        if (pressed) begin
            r = 1'b1;
            n = 32'd0;
        end else if (held) begin
            if (cnt == REP_LAST) begin
                r = 1'b1;
                n = REP_RELOAD;
            end else begin
                n = cnt + 32'd1;
            end
        end
        return {r, n};
    endfunction

    // Two-flop synchroniser plus history flop; keeps tracking while paused
    always_comb begin
        s1_d  = btn_raw;
        s2_d  = s1_q;
        s3_d  = s2_q;
        press = s2_q & ~s3_q;
    end

    // Gravity timer and horizontal auto-repeat counters; all hold while paused
    always_comb begin
        gcnt_d      = gcnt_q;
        lcnt_d      = lcnt_q;
        rcnt_d      = rcnt_q;
        gfire       = 1'b0;
        lreq        = 1'b0;
        rreq        = 1'b0;
        period_last = s2_q[B_DOWN] ? S_LAST : G_LAST;
        if (enable) begin
            // >= so that switching to soft drop with a large count fires at once
            if (gcnt_q >= period_last) begin
                gfire  = 1'b1;
                gcnt_d = 32'd0;
            end else begin
                gcnt_d = gcnt_q + 32'd1;
            end
            {lreq, lcnt_d} = repeat_step(press[B_LEFT], s2_q[B_LEFT], lcnt_q);
            {rreq, rcnt_d} = repeat_step(press[B_RIGHT], s2_q[B_RIGHT], rcnt_q);
        end
    end

    // Fixed-priority arbiter: issue one pending command, merge new requests
    always_comb begin
        req   = {gfire, lreq, rreq, press[B_ROT]};
        grant = 4'b0000;
        if (pend_q[3]) begin
            grant = 4'b1000;
        end else if (pend_q[2]) begin
            grant = 4'b0100;
        end else if (pend_q[1]) begin
            grant = 4'b0010;
        end else if (pend_q[0]) begin
            grant = 4'b0001;
        end
        if (enable) begin
            // A request landing on the flag being issued re-arms it for later
            pend_d = (pend_q & ~grant) | req;
            cmd_d  = grant;
        end else begin
            pend_d = 4'b0000;
            cmd_d  = 4'b0000;
        end
    end

    // State registers; err restarts every flop
    always_ff @(posedge clk) begin
        if (err) begin
            s1_q   <= 4'b0000;
            s2_q   <= 4'b0000;
            s3_q   <= 4'b0000;
            gcnt_q <= 32'd0;
            lcnt_q <= 32'd0;
            rcnt_q <= 32'd0;
            pend_q <= 4'b0000;
            cmd_q  <= 4'b0000;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            gcnt_q <= gcnt_d;
            lcnt_q <= lcnt_d;
            rcnt_q <= rcnt_d;
            pend_q <= pend_d;
            cmd_q  <= cmd_d;
        end
    end

endmodule

// File: tb/tb_block_cmd_gen.sv
// Directed bench for block_cmd_gen with short periods
// (GRAVITY_DIV=8, SOFT_DIV=2, REPEAT_DELAY=6, REPEAT_RATE=3).
// Step k means the k-th rising edge after the most recent err edge;
// outputs are sampled 1 time unit after that edge.
module tb_block_cmd_gen;

    logic clk = 1'b0;
    logic err;
    logic enable;
    logic btn_left;
    logic btn_right;
    logic btn_rot;
    logic btn_down;
    logic drop;
    logic left;
    logic right;
    logic ro;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    // Steps at which each output is expected high
    int qd[$];
    int ql[$];
    int qr[$];
    int qo[$];

    block_cmd_gen #(
        .GRAVITY_DIV (8),
        .SOFT_DIV    (2),
        .REPEAT_DELAY(6),
        .REPEAT_RATE (3)
    ) dut (
        .clk      (clk),
        .err      (err),
        .enable   (enable),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_rot  (btn_rot),
        .btn_down (btn_down),
        .drop     (drop),
        .left     (left),
        .right    (right),
        .ro       (ro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n edges, comparing {drop,left,right,ro} with the expectation queues
    task automatic run_seg(input string tag, input int n);
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            k++;
            e = 4'b0000;
            foreach (qd[j]) if (qd[j] == k) e[3] = 1'b1;
            foreach (ql[j]) if (ql[j] == k) e[2] = 1'b1;
            foreach (qr[j]) if (qr[j] == k) e[1] = 1'b1;
            foreach (qo[j]) if (qo[j] == k) e[0] = 1'b1;
            chk($sformatf("%s@%0d", tag, k), {28'd0, drop, left, right, ro}, {28'd0, e});
        end
    endtask

    // One err edge with buttons low; outputs must be 0 right after it
    task automatic do_reset();
        err       = 1'b1;
        enable    = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_rot   = 1'b0;
        btn_down  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst", {28'd0, drop, left, right, ro}, 32'd0);
        err = 1'b0;
        k   = 0;
    endtask

    task automatic clear_q();
        qd.delete();
        ql.delete();
        qr.delete();
        qo.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        err       = 1'b1;
        enable    = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_rot   = 1'b0;
        btn_down  = 1'b0;
        do_reset();
        do_reset();

        // Gravity only: drop_p sets at edges 8,16,24 so drop shows at 9,17,25
        clear_q();
        qd = '{9, 17, 25};
        do_reset();
        run_seg("grav", 26);

        // Single rotate held 20 cycles: E0=1, ro at E3=4 only
        clear_q();
        qd = '{9, 17, 25};
        qo = '{4};
        do_reset();
        btn_rot = 1'b1;
        run_seg("rot", 20);
        btn_rot = 1'b0;
        run_seg("rot", 6);

        // Left auto-repeat held 20 cycles: E3 + {0,6,9,12,15,18}
        clear_q();
        qd = '{9, 17, 25};
        ql = '{4, 10, 13, 16, 19, 22};
        do_reset();
        btn_left = 1'b1;
        run_seg("rep", 20);
        btn_left = 1'b0;
        run_seg("rep", 8);

        // Collision: left+right pending set at edge 8 together with gravity
        clear_q();
        qd = '{9, 17};
        ql = '{10};
        qr = '{11};
        do_reset();
        run_seg("col", 5);
        btn_left  = 1'b1;
        btn_right = 1'b1;
        run_seg("col", 2);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        run_seg("col", 11);

        // Soft drop held 12 cycles: fires at 3,5,..,13 then normal period resumes
        clear_q();
        qd = '{4, 6, 8, 10, 12, 14, 22, 30};
        do_reset();
        btn_down = 1'b1;
        run_seg("soft", 12);
        btn_down = 1'b0;
        run_seg("soft", 19);

        // Pause with toggling buttons, resume from held gcnt=4, then err mid-repeat
        clear_q();
        qd = '{39, 47, 58, 66};
        ql = '{43, 62};
        do_reset();
        run_seg("pz", 4);
        enable = 1'b0;
        for (int p = 5; p <= 34; p++) begin
            if (p < 29) begin
                btn_left  = p[0];
                btn_right = ~p[0];
                btn_rot   = p[1];
                btn_down  = p[2];
            end else begin
                btn_left  = 1'b0;
                btn_right = 1'b0;
                btn_rot   = 1'b0;
                btn_down  = 1'b0;
            end
            run_seg("pz", 1);
        end
        enable = 1'b1;
        run_seg("resume", 5);
        btn_left = 1'b1;
        run_seg("held", 9);
        err      = 1'b1;
        btn_left = 1'b0;
        run_seg("err", 1);
        err = 1'b0;
        run_seg("post", 9);
        btn_left = 1'b1;
        run_seg("repress", 8);
        btn_left = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
